channel_dump: RTL and testbench

- Downstream of the capture controller. On a `dump` request it reads one channel's full circular capture buffer, oldest sample first, from the sample RAM.
- Each sample is presented as a byte on a valid/ready stream to the host transmitter (UART/SPI TX wrapper).
- Signals `dump_fin` back to the capture controller so its DUMP state can return to IDLE.

---
 rtl/channel_dump.sv | 166 ++++++++++++++++
 tb/tb_channel_dump.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/channel_dump.sv
// rtl/channel_dump.sv - streams one channel's circular capture buffer, oldest sample first
//
// Optional build macro: DUMP_HEADER_EN prefixes each dump with 8'hA5 and {6'b0, chan}.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   dump                start request, sampled only when idle
//   dump_chan           channel select, latched at start
//   trace_end           address of the newest sample, latched at start
//   ram_en, ram_addr    RAM read request (data returns one cycle later)
//   ram_chan            latched channel, selects the RAM bank
//   ram_rdata           RAM read data
//   tx_data, tx_valid   byte stream to the transmitter
//   tx_ready            transmitter accepts on tx_valid & tx_ready
//   busy                high from the start cycle through the dump_fin cycle
//   dump_fin            one-cycle pulse after the last byte is accepted
module channel_dump #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dump,
    input  logic [1:0]    dump_chan,
    input  logic [AW-1:0] trace_end,
    output logic          ram_en,
    output logic [AW-1:0] ram_addr,
    output logic [1:0]    ram_chan,
    input  logic [DW-1:0] ram_rdata,
    output logic [DW-1:0] tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          busy,
    output logic          dump_fin
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        LAT,
        SEND,
        FIN
`ifdef DUMP_HEADER_EN
        ,
        HDR0,
        HDR1
`endif
    } state_t;

    // cnt is one bit wider than the address so a full 2**AW pass is countable.
    localparam logic [AW:0] LAST = {1'b0, {AW{1'b1}}};

    state_t        state, next_state;
    logic [AW-1:0] start;
    logic [AW:0]   cnt;
    logic          hs;

    assign hs = tx_valid & tx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (dump) begin
`ifdef DUMP_HEADER_EN
                    next_state = HDR0;
`else
                    next_state = RD;
`endif
                end
            end
`ifdef DUMP_HEADER_EN
            HDR0: if (hs) next_state = HDR1;
            HDR1: if (hs) next_state = RD;
`endif
            RD:   next_state = LAT;
            LAT:  next_state = SEND;
            SEND: begin
                if (hs) next_state = (cnt == LAST) ? FIN : RD;
            end
            FIN:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered and loaded on the transition into the state
    // that presents them, so ram_en is high exactly during RD and tx_valid
    // is high exactly during SEND (and the header states).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_en   <= 1'b0;
            ram_addr <= '0;
            ram_chan <= 2'd0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            dump_fin <= 1'b0;
            start    <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dump) begin
                        ram_chan <= dump_chan;
                        start    <= trace_end + AW'(1);
                        cnt      <= '0;
                        busy     <= 1'b1;
`ifdef DUMP_HEADER_EN
                        tx_data  <= DW'(8'hA5);
                        tx_valid <= 1'b1;
`else
                        ram_en   <= 1'b1;
                        ram_addr <= trace_end + AW'(1);
`endif
                    end
                end
`ifdef DUMP_HEADER_EN
                HDR0: begin
                    if (hs) tx_data <= DW'({6'b0, ram_chan});
                end
                HDR1: begin
                    if (hs) begin
                        tx_valid <= 1'b0;
                        ram_en   <= 1'b1;
                        ram_addr <= start;
                    end
                end
`endif
                RD: begin
                    ram_en <= 1'b0;
                end
                LAT: begin
                    tx_data  <= ram_rdata;
                    tx_valid <= 1'b1;
                end
                SEND: begin
                    if (hs) begin
                        tx_valid <= 1'b0;
                        cnt      <= cnt + (AW+1)'(1);
                        if (cnt == LAST) begin
                            dump_fin <= 1'b1;
                        end else begin
                            // Address arithmetic wraps naturally at AW bits.
                            ram_en   <= 1'b1;
                            ram_addr <= start + cnt[AW-1:0] + AW'(1);
                        end
                    end
                end
                FIN: begin
                    dump_fin <= 1'b0;
                    busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_channel_dump.sv
// tb/tb_channel_dump.sv - randomized self-checking bench for channel_dump
module tb_channel_dump;
    localparam int AW    = 9;
    localparam int DW    = 8;
    localparam int N     = 512;
    localparam int LIMIT = 8000;
`ifdef DUMP_HEADER_EN
    localparam int FIRST_VALID = 0;
    localparam int FIN_CYCLE   = 3 * N + 2;
`else
    localparam int FIRST_VALID = 2;
    localparam int FIN_CYCLE   = 3 * N;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          dump;
    logic [1:0]    dump_chan;
    logic [AW-1:0] trace_end;
    logic          ram_en;
    logic [AW-1:0] ram_addr;
    logic [1:0]    ram_chan;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          busy;
    logic          dump_fin;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [4][N];

    channel_dump #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .dump      (dump),
        .dump_chan (dump_chan),
        .trace_end (trace_end),
        .ram_en    (ram_en),
        .ram_addr  (ram_addr),
        .ram_chan  (ram_chan),
        .ram_rdata (ram_rdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .dump_fin  (dump_fin)
    );

    always #5 clk = ~clk;

    // Synchronous sample RAM: data valid one cycle after ram_en.
    always @(posedge clk) begin
        if (ram_en) ram_rdata <= mem[ram_chan][ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_dump(input logic [8:0] te, input logic [1:0] ch, input int duty,
                            input int disturb_at, input int reset_at);
        logic [7:0] exp_q[$];
        logic [8:0] sa;
        int  n, cyc, fin_cyc, first_v, byte_bad, first_bad, stab_bad, busy_bad, fin_cnt, dist_cnt;
        int  post_bad;
        bit  pend, did_dist, did_rst;
        logic [7:0] pend_data;

        exp_q.delete();
`ifdef DUMP_HEADER_EN
        exp_q.push_back(8'hA5);
        exp_q.push_back({6'b0, ch});
`endif
        for (int i = 0; i < N; i++) exp_q.push_back(mem[ch][(int'(te) + 1 + i) % N]);
        sa = te + 9'd1;
        n = 0; cyc = 0; fin_cyc = -1; first_v = -1; byte_bad = 0; first_bad = -1;
        stab_bad = 0; busy_bad = 0; fin_cnt = 0; dist_cnt = 0; post_bad = 0;
        pend = 0; did_dist = 0; did_rst = 0; pend_data = '0;

        @(posedge clk); #1;
        dump = 1'b1; trace_end = te; dump_chan = ch;
        @(posedge clk); #1;
        dump = 1'b0;
        tx_ready = (int'($urandom_range(99)) < duty);
        chk("start_busy", 32'(busy), 1);
        chk("start_chan", 32'(ram_chan), 32'(ch));
`ifndef DUMP_HEADER_EN
        chk("start_ram_en", 32'(ram_en), 1);
        chk("start_addr", 32'(ram_addr), 32'(sa));
`endif

        while (cyc < LIMIT) begin
            @(negedge clk);
            if (pend && !(tx_valid && tx_data == pend_data)) stab_bad++;
            if (tx_valid && first_v < 0) first_v = cyc;
            if (!busy) busy_bad++;
            if (tx_valid && tx_ready) begin
                if (n >= exp_q.size()) begin
                    byte_bad++;
                end else if (tx_data !== exp_q[n]) begin
                    byte_bad++;
                    if (first_bad < 0) first_bad = n;
                end
                n++;
            end
            pend = tx_valid && !tx_ready;
            pend_data = tx_data;
            if (dump_fin) begin
                fin_cnt++;
                fin_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
            cyc++;
            tx_ready = (int'($urandom_range(99)) < duty);
            if (dist_cnt > 0) begin
                dist_cnt--;
                if (dist_cnt == 0) dump = 1'b0;
            end
            if (n == disturb_at && !did_dist) begin
                did_dist = 1;
                dump = 1'b1;
                trace_end = 9'($urandom);
                dump_chan = ~ch;
                dist_cnt = 6;
            end
            if (n == reset_at && !did_rst) begin
                did_rst = 1;
                rst = 1'b1;
                #1;
                break;
            end
        end

        if (did_rst) begin
            chk("rst_tx_valid", 32'(tx_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_ram_en", 32'(ram_en), 0);
            chk("rst_bytes_before", 32'(byte_bad), 0);
            @(posedge clk); #1;
            rst = 1'b0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (dump_fin || busy || tx_valid) post_bad++;
            end
            chk("rst_no_fin", 32'(post_bad), 0);
        end else begin
            if (first_bad >= 0) $display("first bad byte index %0d", first_bad);
            chk("byte_order", 32'(byte_bad), 0);
            chk("handshakes", 32'(n), 32'(exp_q.size()));
            chk("tx_stable", 32'(stab_bad), 0);
            chk("busy_high", 32'(busy_bad), 0);
            chk("fin_seen", 32'(fin_cnt), 1);
            chk("ram_chan_held", 32'(ram_chan), 32'(ch));
            if (duty == 100) begin
                chk("first_valid_cyc", 32'(first_v), 32'(FIRST_VALID));
                chk("fin_cyc", 32'(fin_cyc), 32'(FIN_CYCLE));
            end
            @(posedge clk); #1;
            @(negedge clk);
            chk("fin_one_pulse", 32'(dump_fin), 0);
            chk("busy_after", 32'(busy), 0);
            chk("valid_after", 32'(tx_valid), 0);
        end
        dump = 1'b0;
        tx_ready = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < N; a++) begin
            mem[0][a] = 8'(a);
            for (int c = 1; c < 4; c++) mem[c][a] = 8'($urandom);
        end
        rst = 1'b1; dump = 1'b0; dump_chan = 2'd0; trace_end = '0; tx_ready = 1'b0;
        #1;
        chk("reset_ram_en", 32'(ram_en), 0);
        chk("reset_ram_addr", 32'(ram_addr), 0);
        chk("reset_ram_chan", 32'(ram_chan), 0);
        chk("reset_tx_data", 32'(tx_data), 0);
        chk("reset_tx_valid", 32'(tx_valid), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_dump_fin", 32'(dump_fin), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        run_dump(9'd99, 2'd0, 100, -1, -1);
        run_dump(9'd511, 2'd1, 100, -1, -1);
        run_dump(9'($urandom), 2'd2, 30, 200, -1);
        run_dump(9'($urandom), 2'd3, 60, -1, 300);
        run_dump(9'($urandom), 2'd0, 50, -1, -1);
`ifdef DUMP_HEADER_EN
        run_dump(9'($urandom), 2'd2, 100, -1, -1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
